// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side controller for the UART RX path.
//   - Prescaler: generates the per-bit o_half / o_strobe sample pulses for the
//     RX FSM while it holds i_prescaler_en high.
//   - FIFO: buffers completed characters tagged with their parity status and
//     presents the head entry on a valid/ready read port.
//   - Status: sticky overrun / parity-seen flags and a level interrupt.
//
// Optional feature (compile-time macro UART_RX_TIMEOUT_EN):
//   Adds a sticky receive-idle timeout flag on o_timeout, also ORed into o_irq.
//
// Ports:
//   i_clk            clock, baudrate x Oversample
//   i_rst_n          asynchronous active-low reset
//   i_prescaler_en   enables the sample-timing counter (held at 0 otherwise)
//   o_strobe         one-cycle pulse at each bit-period end
//   o_half           one-cycle pulse at each bit-period midpoint
//   i_rx_data        received character
//   i_rx_write_en    one-cycle pulse, i_rx_data / i_parity_error are complete
//   i_parity_error   parity result for the character
//   o_rd_data        head-of-FIFO character
//   o_rd_parity_err  parity tag of the head entry
//   o_rd_valid       FIFO not empty
//   i_rd_ready       host accepts the head entry
//   o_level          current FIFO occupancy
//   o_overrun        sticky: a character was dropped on a full FIFO
//   o_parity_seen    sticky: a character with a parity error was stored
//   i_clr_status     one-cycle pulse clearing all sticky flags
//   o_timeout        sticky idle timeout (only with UART_RX_TIMEOUT_EN)
//   o_irq            level interrupt
//
// Read handshake: an entry transfers on every rising edge where o_rd_valid and
// i_rd_ready are both high. o_rd_valid does not depend on i_rd_ready, and the
// head entry stays stable until it is transferred.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int DataLength = 8,
   parameter int Oversample = 16,
   parameter int FifoDepth  = 4,
   parameter int IrqLevel   = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_prescaler_en,
   output logic                          o_strobe,
   output logic                          o_half,
   input  logic [DataLength-1:0]         i_rx_data,
   input  logic                          i_rx_write_en,
   input  logic                          i_parity_error,
   output logic [DataLength-1:0]         o_rd_data,
   output logic                          o_rd_parity_err,
   output logic                          o_rd_valid,
   input  logic                          i_rd_ready,
   output logic [$clog2(FifoDepth):0]    o_level,
   output logic                          o_overrun,
   output logic                          o_parity_seen,
   input  logic                          i_clr_status,
`ifdef UART_RX_TIMEOUT_EN
   output logic                          o_timeout,
`endif
   output logic                          o_irq
);

   localparam int PtrW = $clog2(FifoDepth);
   localparam int LvlW = PtrW + 1;
   localparam int PcW  = $clog2(Oversample);

   localparam logic [PcW-1:0]  PcLast  = PcW'(Oversample - 1);
   localparam logic [PcW-1:0]  PcHalf  = PcW'(Oversample / 2 - 1);
   localparam logic [LvlW-1:0] LvlFull = LvlW'(FifoDepth);
   localparam logic [LvlW-1:0] LvlIrq  = LvlW'(IrqLevel);

   // ---------------------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------------------
   logic [PcW-1:0] pc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc <= '0;
      end else if (!i_prescaler_en) begin
         pc <= '0;
      end else if (pc == PcLast) begin
         pc <= '0;
      end else begin
         pc <= pc + 1'b1;
      end
   end

   // Oversample is even and >= 4, so PcHalf != PcLast and the pulses never overlap.
   assign o_half   = i_prescaler_en && (pc == PcHalf);
   assign o_strobe = i_prescaler_en && (pc == PcLast);

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   logic [DataLength:0] mem [FifoDepth];
   logic [PtrW-1:0]     wr_ptr;
   logic [PtrW-1:0]     rd_ptr;
   logic [LvlW-1:0]     count;
   logic                full;
   logic                empty;
   logic                pop;
   logic                push;

   assign full  = (count == LvlFull);
   assign empty = (count == '0);
   assign pop   = !empty && i_rd_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = i_rx_write_en && (!full || pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FifoDepth; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {i_parity_error, i_rx_data};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign o_rd_data       = mem[rd_ptr][DataLength-1:0];
   assign o_rd_parity_err = mem[rd_ptr][DataLength];
   assign o_rd_valid      = !empty;
   assign o_level         = count;

   // ---------------------------------------------------------------------------
   // Sticky status; a set event beats a coincident clear.
   // ---------------------------------------------------------------------------
   logic overrun_q;
   logic parity_seen_q;
   logic overrun_set;
   logic parity_set;

   assign overrun_set = i_rx_write_en && full && !pop;
   assign parity_set  = push && i_parity_error;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         overrun_q     <= 1'b0;
         parity_seen_q <= 1'b0;
      end else begin
         overrun_q     <= overrun_set | (overrun_q & ~i_clr_status);
         parity_seen_q <= parity_set  | (parity_seen_q & ~i_clr_status);
      end
   end

   assign o_overrun     = overrun_q;
   assign o_parity_seen = parity_seen_q;

`ifdef UART_RX_TIMEOUT_EN
   // Four character times of 10 bits each with nothing moving through the FIFO.
   localparam int TimeoutCycles = 4 * 10 * Oversample;
   localparam int IdleW         = $clog2(TimeoutCycles + 1);
   localparam logic [IdleW-1:0] IdleLimit = IdleW'(TimeoutCycles);

   logic [IdleW-1:0] idle_cnt;
   logic             idle_clr;
   logic             timeout_q;
   logic             timeout_set;

   assign idle_clr    = empty || push || pop;
   // Set on the same edge that the counter reaches the limit.
   assign timeout_set = !idle_clr && (idle_cnt == IdleLimit - 1'b1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idle_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (idle_clr) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IdleLimit) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
         timeout_q <= timeout_set | (timeout_q & ~i_clr_status);
      end
   end

   assign o_timeout = timeout_q;
   assign o_irq     = (count >= LvlIrq) | overrun_q | parity_seen_q | timeout_q;
`else
   assign o_irq     = (count >= LvlIrq) | overrun_q | parity_seen_q;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART RX path. Generates the `i_strobe`/`i_half` sample timing the RX FSM consumes, gated by its `o_prescaler_en`. Buffers each completed character in a small FIFO tagged with its parity status, and presents it to the host over a valid/ready read port. Also maintains sticky overrun/parity status and a level interrupt.

## Interface
Parameters:
- `DataLength`, 8: character width; matches the RX FSM.
- `Oversample`, 16: clock cycles per bit; even, ≥ 4.
- `FifoDepth`, 4: entries; power of two, ≥ 2.
- `IrqLevel`, 1: FIFO occupancy at or above which `o_irq` asserts; 1..`FifoDepth`.

Ports:
- `i_clk`, in, 1: clock at baudrate × `Oversample`.
- `i_rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `i_prescaler_en`, in, 1: from RX FSM; enables the sample-timing counter.
- `o_strobe`, out, 1: one-cycle pulse at each bit-period end.
- `o_half`, out, 1: one-cycle pulse at each bit-period midpoint.
- `i_rx_data`, in, `DataLength`: received character from the RX FSM.
- `i_rx_write_en`, in, 1: one-cycle pulse; `i_rx_data` is complete.
- `i_parity_error`, in, 1: parity result for the character; sampled with `i_rx_write_en`.
- `o_rd_data`, out, `DataLength`: head-of-FIFO character.
- `o_rd_parity_err`, out, 1: parity tag for the head entry.
- `o_rd_valid`, out, 1: FIFO not empty.
- `i_rd_ready`, in, 1: host accepts the head entry.
- `o_level`, out, `$clog2(FifoDepth)+1`: current occupancy.
- `o_overrun`, out, 1: sticky; a character was dropped because the FIFO was full.
- `o_parity_seen`, out, 1: sticky; a character was pushed with a parity error.
- `i_clr_status`, in, 1: one-cycle pulse clearing all sticky flags.
- `o_irq`, out, 1: level interrupt.

## Operation
Prescaler:
- Counter `pc` spans 0..`Oversample`-1.
- While `i_prescaler_en`=0: `pc` is held at 0, and `o_strobe`=`o_half`=0.
- While `i_prescaler_en`=1: `pc` increments and wraps to 0 after `Oversample`-1.
- `o_half`=1 when `pc`==`Oversample`/2-1.
- `o_strobe`=1 when `pc`==`Oversample`-1.
- Both outputs decode combinationally from `pc` and `i_prescaler_en`. They are never high in the same cycle.

FIFO:
- Circular buffer with `$clog2(FifoDepth)`-bit read/write pointers that wrap naturally, plus an occupancy count.
- Each entry is `{parity, data}`.
- Push occurs on `i_rx_write_en`.
  - Not full: push accepted.
  - Full and no pop this cycle: push dropped, `o_overrun` set.
- Pop occurs when `o_rd_valid` && `i_rd_ready`.
- Simultaneous push and pop when full: both accepted, no overrun, level unchanged.
- Simultaneous push and pop when empty: push only; the pop is a no-op because `o_rd_valid`=0.
- `o_rd_data`/`o_rd_parity_err` show the entry at the read pointer. They are undefined-but-stable when empty; drive the stored RAM value, no X-masking required.

Status and interrupt:
- `o_parity_seen` is set on an accepted push with `i_parity_error`=1.
- `i_clr_status` clears all sticky flags. A set event in the same cycle wins, so the flag stays 1.
- `o_irq` = (`o_level` ≥ `IrqLevel`) | `o_overrun` | `o_parity_seen` (| `timeout` when configured).

Reset: all counters, pointers and sticky flags go to 0. Outputs reset values:
- `o_strobe`=0, `o_half`=0, `o_rd_valid`=0, `o_level`=0, `o_overrun`=0, `o_parity_seen`=0, `o_irq`=0.
- `o_rd_data`=0, `o_rd_parity_err`=0: FIFO storage is reset.

Reset asserted mid-character or mid-read discards all FIFO contents immediately.

## Timing
- `pc` increments on the first rising edge with `i_prescaler_en`=1.
- First `o_half` is `Oversample`/2 cycles after that edge. First `o_strobe` is `Oversample` cycles after it. Both then repeat every `Oversample` cycles.
- Push to `o_rd_valid`: 1 cycle, registered. `o_rd_valid` rises the cycle after `i_rx_write_en`.
- Pop: `o_rd_data` advances to the next entry the cycle after the accepting edge.
- `o_level`, sticky flags and `o_irq` update on the edge following the causing event.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - Adds a 1-bit sticky `timeout` flag, ORed into `o_irq`, and an output port `o_timeout`.
  - An idle counter counts cycles while the FIFO is non-empty and no push or pop occurs.
  - The counter clears on any push, pop, or when the FIFO is empty.
  - Reaching 4 × 10 × `Oversample` cycles (four character times) sets `timeout`.
  - `timeout` is cleared by `i_clr_status` and by reset.
- `UART_RX_TIMEOUT_EN` not defined: no counter, no `o_timeout` port, and `o_irq` omits the term.

## Test plan
All scenarios use default parameters unless stated.

- **Prescaler:** `i_prescaler_en` held high 40 cycles from reset → `o_half` at cycles 8, 24, 40 and `o_strobe` at cycles 16, 32; drop enable → both 0, `pc` restarts at 0.
- **Push/read:** push 0xA5 (parity 0) → `o_rd_valid`=1 next cycle, `o_rd_data`=0xA5, `o_level`=1, `o_irq`=1; `i_rd_ready`=1 → `o_rd_valid`=0, `o_irq`=0.
- **Overrun:** push 0x01..0x04, then push 0x05 with `i_rd_ready`=0 → `o_overrun`=1, level 4; reads return 0x01..0x04 in order; `i_clr_status` → `o_overrun`=0.
- **Full with simultaneous pop:** full FIFO, push 0x77 with `i_rd_ready`=1 → no overrun, level stays 4, 0x77 read last.
- **Parity and clear race:** push 0x3C with `i_parity_error`=1 → `o_rd_parity_err`=1, `o_parity_seen`=1; then `i_clr_status` coincident with another parity-error push → flag remains 1.
- **Reset mid-operation:** reset with 3 entries queued → `o_level`=0 and `o_rd_valid`=0 immediately. With `UART_RX_TIMEOUT_EN`: one entry idle 640 cycles → `o_timeout`=1 at cycle 640, not at 639.
